// File: rtl/layer1_sram_ctrl_pkg.sv
// Shared types and default sizes for the layer-1 SRAM controller.
// FSM state, round-robin pointer, DEPTH/AW/DW defaults.
package layer1_sram_ctrl_pkg;

  localparam int DEPTH_DEF = 912;
  localparam int AW_DEF    = 10;
  localparam int DW_DEF    = 128;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_CLEAR = 1'b1
  } state_e;

  // Names the requester that currently holds priority.
  typedef enum logic {
    RR_WR   = 1'b0,
    RR_HOST = 1'b1
  } rr_ptr_e;

endpackage

// File: rtl/layer1_sram_ctrl_if.sv
// Requester-side bus of the SRAM controller: writer, host,
// reader, clear control and error flag; master=clients, slave=ctrl.
interface layer1_sram_ctrl_if
  import layer1_sram_ctrl_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF
) ();

  logic          wr_valid;
  logic          wr_ready;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;

  logic          host_req;
  logic          host_we;
  logic [AW-1:0] host_addr;
  logic [DW-1:0] host_wdata;
  logic          host_gnt;
  logic [DW-1:0] host_rdata;
  logic          host_rvalid;

  logic          rd_valid;
  logic          rd_ready;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data;
  logic          rd_dvalid;

  logic          clr_start;
  logic          clr_busy;
  logic          clr_done;
  logic          addr_err;

  modport master (
    output wr_valid, wr_addr, wr_data,
    input  wr_ready,
    output host_req, host_we, host_addr, host_wdata,
    input  host_gnt, host_rdata, host_rvalid,
    output rd_valid, rd_addr,
    input  rd_ready, rd_data, rd_dvalid,
    output clr_start,
    input  clr_busy, clr_done, addr_err
  );

  modport slave (
    input  wr_valid, wr_addr, wr_data,
    output wr_ready,
    input  host_req, host_we, host_addr, host_wdata,
    output host_gnt, host_rdata, host_rvalid,
    input  rd_valid, rd_addr,
    output rd_ready, rd_data, rd_dvalid,
    input  clr_start,
    output clr_busy, clr_done, addr_err
  );

endinterface

// File: rtl/layer1_sram_ctrl_rr_arb2.sv
// Two-requester round-robin arbiter; req0 wins ties after reset.
// Ports: clk, rst_n, en_i, req0_i/req1_i in; gnt0_o/gnt1_o out.
module rr_arb2
  import layer1_sram_ctrl_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic en_i,
  input  logic req0_i,
  input  logic req1_i,
  output logic gnt0_o,
  output logic gnt1_o
);

  rr_ptr_e ptr_q, ptr_d;

  always_comb begin
    gnt0_o = en_i & req0_i
           & ((ptr_q == RR_WR) | ~req1_i);
    gnt1_o = en_i & req1_i
           & ((ptr_q == RR_HOST) | ~req0_i);
    ptr_d  = ptr_q;
    // The winner drops to lower priority.
    unique case (1'b1)
      gnt0_o:  ptr_d = RR_HOST;
      gnt1_o:  ptr_d = RR_WR;
      default: ptr_d = ptr_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= RR_WR;
    else        ptr_q <= ptr_d;
  end

endmodule

// File: rtl/layer1_sram_ctrl.sv
// Dual-port SRAM controller: port A = writer/host (round-robin),
// port B = reader, plus a zero-fill CLEAR sweep and sticky addr_err.
// Ports: CK, RSTN, bus (slave), SRAM pins OEA/OEB/WEAN/WEBN/A/B/DIA/DIB/DOA/DOB.
module layer1_sram_ctrl
  import layer1_sram_ctrl_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int AW    = AW_DEF,
  parameter int DW    = DW_DEF
) (
  input  logic          CK,
  input  logic          RSTN,
  layer1_sram_ctrl_if.slave bus,
  output logic          OEA,
  output logic          OEB,
  output logic          WEAN,
  output logic          WEBN,
  output logic [AW-1:0] A,
  output logic [AW-1:0] B,
  output logic [DW-1:0] DIA,
  output logic [DW-1:0] DIB,
  input  logic [DW-1:0] DOA,
  input  logic [DW-1:0] DOB
);

  localparam logic [AW:0]   LIMIT = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] LAST  = AW'(DEPTH - 1);

  state_e        state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
  logic          hval_q, hval_d;
  logic          dval_q, dval_d;

  logic          idle;
  logic          wr_gnt, host_gnt;
  logic          wr_ok, host_ok, rd_ok;
  logic          a_use, rd_rdy, rd_fire;
  logic [AW-1:0] a_addr;

  assign idle    = (state_q == S_IDLE);
  assign wr_ok   = {1'b0, bus.wr_addr} < LIMIT;
  assign host_ok = {1'b0, bus.host_addr} < LIMIT;
  assign rd_ok   = {1'b0, bus.rd_addr} < LIMIT;

  rr_arb2 u_arb (
    .clk    (CK),
    .rst_n  (RSTN),
    .en_i   (idle),
    .req0_i (bus.wr_valid),
    .req1_i (bus.host_req),
    .gnt0_o (wr_gnt),
    .gnt1_o (host_gnt)
  );

  // Port B backs off only when port A really touches the same word.
  always_comb begin
    a_use   = (wr_gnt & wr_ok) | (host_gnt & host_ok);
    a_addr  = wr_gnt ? bus.wr_addr : bus.host_addr;
    rd_rdy  = idle & ~(bus.rd_valid & a_use
                       & (bus.rd_addr == a_addr));
    rd_fire = bus.rd_valid & rd_rdy;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (bus.clr_start) begin
          state_d = S_CLEAR;
          cnt_d   = '0;
        end
      end
      S_CLEAR: begin
        if (cnt_q == LAST) begin
          state_d = S_IDLE;
          cnt_d   = '0;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + AW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    err_d = err_q;
    if (idle & bus.clr_start) err_d = 1'b0;
    // A same-cycle bad request outranks the clear.
    if ((wr_gnt & ~wr_ok) | (host_gnt & ~host_ok)
        | (rd_fire & ~rd_ok))
      err_d = 1'b1;
    hval_d = host_gnt & ~bus.host_we & host_ok;
    dval_d = rd_fire & rd_ok;
  end

  always_comb begin
    OEA  = 1'b0;
    WEAN = 1'b1;
    A    = '0;
    DIA  = '0;
    OEB  = 1'b0;
    B    = '0;
    if (!idle) begin
      WEAN = 1'b0;
      A    = cnt_q;
    end else if (wr_gnt & wr_ok) begin
      WEAN = 1'b0;
      A    = bus.wr_addr;
      DIA  = bus.wr_data;
    end else if (host_gnt & host_ok) begin
      A = bus.host_addr;
      if (bus.host_we) begin
        WEAN = 1'b0;
        DIA  = bus.host_wdata;
      end else begin
        OEA = 1'b1;
      end
    end
    if (dval_d) begin
      OEB = 1'b1;
      B   = bus.rd_addr;
    end
  end

  assign WEBN = 1'b1;
  assign DIB  = '0;

  assign bus.wr_ready    = wr_gnt;
  assign bus.host_gnt    = host_gnt;
  assign bus.host_rdata  = DOA;
  assign bus.host_rvalid = hval_q;
  assign bus.rd_ready    = rd_rdy;
  assign bus.rd_data     = DOB;
  assign bus.rd_dvalid   = dval_q;
  assign bus.clr_busy    = ~idle;
  assign bus.clr_done    = done_q;
  assign bus.addr_err    = err_q;

  always_ff @(posedge CK or negedge RSTN) begin
    if (!RSTN) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      hval_q  <= 1'b0;
      dval_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      err_q   <= err_d;
      hval_q  <= hval_d;
      dval_q  <= dval_d;
    end
  end

endmodule

// File: tb/tb_layer1_sram_ctrl.sv
// Bench for layer1_sram_ctrl: SRAM pin model, vector table,
// random traffic vs. a shadow-memory scoreboard, clear/reset sequences.
module tb_layer1_sram_ctrl;
  import layer1_sram_ctrl_pkg::*;

  localparam int D = 912;
  localparam logic [127:0] AA = {16{8'hAA}};
  localparam logic [127:0] HD = {4{32'h1234_5678}};

  logic CK = 1'b0;
  logic RSTN = 1'b0;
  logic OEA, OEB, WEAN, WEBN;
  logic [9:0] A, B;
  logic [127:0] DIA, DIB, DOA, DOB;

  always #5 CK = ~CK;

  layer1_sram_ctrl_if #(.AW(10), .DW(128)) bus ();

  layer1_sram_ctrl #(.DEPTH(D), .AW(10), .DW(128)) dut (
    .CK(CK), .RSTN(RSTN), .bus(bus),
    .OEA(OEA), .OEB(OEB), .WEAN(WEAN), .WEBN(WEBN),
    .A(A), .B(B), .DIA(DIA), .DIB(DIB),
    .DOA(DOA), .DOB(DOB)
  );

  logic [127:0] sram [0:1023];
  always @(posedge CK) begin
    if (!WEAN) sram[A] <= DIA;
    if (OEA) DOA <= sram[A];
    if (OEB) DOB <= sram[B];
  end

  int errs = 0;
  int checks = 0;

  logic [127:0] ref_mem [D];
  bit known [D];
  bit last_host, m_err;
  bit ph, pr, ph_k, pr_k;
  logic [127:0] ph_v, pr_v;

  task automatic chk(input string nm,
                     input logic [127:0] act,
                     input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    last_host = 1'b1;
    m_err = 1'b0;
    ph = 1'b0;
    pr = 1'b0;
    for (int i = 0; i < D; i++) known[i] = 1'b0;
  endtask

  task automatic idle_in();
    bus.wr_valid = 0; bus.host_req = 0; bus.host_we = 0;
    bus.rd_valid = 0; bus.clr_start = 0;
    bus.wr_addr = 0; bus.host_addr = 0; bus.rd_addr = 0;
    bus.wr_data = 0; bus.host_wdata = HD;
  endtask

  // One clock of traffic checked against the rules; inputs already set.
  task automatic cycle();
    bit ew, eg, er, wok, hok, rok, ause;
    bit nph, npr, nphk, nprk;
    logic [9:0] aadr;
    logic [127:0] nphv, nprv;
    #1;
    wok = bus.wr_addr < D;
    hok = bus.host_addr < D;
    rok = bus.rd_addr < D;
    ew = bus.wr_valid && (!bus.host_req || last_host);
    eg = bus.host_req && (!bus.wr_valid || !last_host);
    ause = (ew && wok) || (eg && hok);
    aadr = ew ? bus.wr_addr : bus.host_addr;
    er = !(bus.rd_valid && ause && bus.rd_addr == aadr);
    chk("wr_ready", bus.wr_ready, ew);
    chk("host_gnt", bus.host_gnt, eg);
    chk("rd_ready", bus.rd_ready, er);
    chk("host_rvalid", bus.host_rvalid, ph);
    if (ph && ph_k) chk("host_rdata", bus.host_rdata, ph_v);
    chk("rd_dvalid", bus.rd_dvalid, pr);
    if (pr && pr_k) chk("rd_data", bus.rd_data, pr_v);
    chk("addr_err", bus.addr_err, m_err);
    chk("clr_busy", bus.clr_busy, 0);
    chk("clr_done", bus.clr_done, 0);
    chk("WEAN", WEAN, !((ew && wok) || (eg && hok && bus.host_we)));
    chk("OEA", OEA, eg && hok && !bus.host_we);
    chk("OEB", OEB, bus.rd_valid && er && rok);
    if (ause) chk("A", A, aadr);
    nph = eg && !bus.host_we && hok;
    nphk = 0; nphv = 0;
    if (nph) begin nphk = known[bus.host_addr]; nphv = ref_mem[bus.host_addr]; end
    npr = bus.rd_valid && er && rok;
    nprk = 0; nprv = 0;
    if (npr) begin nprk = known[bus.rd_addr]; nprv = ref_mem[bus.rd_addr]; end
    if (ew && wok) begin
      ref_mem[bus.wr_addr] = bus.wr_data; known[bus.wr_addr] = 1;
    end
    if (eg && hok && bus.host_we) begin
      ref_mem[bus.host_addr] = bus.host_wdata; known[bus.host_addr] = 1;
    end
    if ((ew && !wok) || (eg && !hok) || (bus.rd_valid && er && !rok))
      m_err = 1;
    if (ew) last_host = 0;
    if (eg) last_host = 1;
    @(posedge CK); #1;
    ph = nph; ph_k = nphk; ph_v = nphv;
    pr = npr; pr_k = nprk; pr_v = nprv;
  endtask

  function automatic logic [9:0] raddr();
    logic [9:0] x;
    if ($urandom % 20 == 0) x = 10'($urandom_range(912, 1023));
    else x = 10'($urandom % 16);
    return x;
  endfunction

  typedef struct {
    bit wv; logic [9:0] wa; logic [127:0] wd;
    bit hr; bit hwe; logic [9:0] ha;
    bit rv; logic [9:0] ra;
    bit ewr; bit egnt; bit erd;
  } vec_t;

  vec_t tbl [12];

  initial begin
    int busy_n, stall_n, done_n;
    bit exit_done;
    tbl[0]  = '{1, 1,   128'h11, 1, 1, 2,   0, 0,   1, 0, 1};
    tbl[1]  = '{1, 1,   128'h11, 1, 1, 2,   0, 0,   0, 1, 1};
    tbl[2]  = '{1, 3,   128'h33, 1, 1, 4,   0, 0,   1, 0, 1};
    tbl[3]  = '{1, 3,   128'h33, 1, 1, 4,   0, 0,   0, 1, 1};
    tbl[4]  = '{1, 5,   AA,      0, 0, 0,   0, 0,   1, 0, 1};
    tbl[5]  = '{0, 0,   0,       0, 0, 0,   1, 5,   0, 0, 1};
    tbl[6]  = '{1, 100, 128'h64, 0, 0, 0,   1, 100, 1, 0, 0};
    tbl[7]  = '{0, 0,   0,       0, 0, 0,   1, 100, 0, 0, 1};
    tbl[8]  = '{0, 0,   0,       1, 0, 5,   1, 5,   0, 1, 0};
    tbl[9]  = '{0, 0,   0,       1, 0, 912, 1, 912, 0, 1, 1};
    tbl[10] = '{1, 100, 128'h65, 1, 0, 100, 0, 0,   1, 0, 1};
    tbl[11] = '{0, 0,   0,       0, 0, 0,   0, 0,   0, 0, 1};

    idle_in();
    model_reset();
    #2;
    chk("rst clr_busy", bus.clr_busy, 0);
    chk("rst clr_done", bus.clr_done, 0);
    chk("rst addr_err", bus.addr_err, 0);
    chk("rst host_rvalid", bus.host_rvalid, 0);
    chk("rst rd_dvalid", bus.rd_dvalid, 0);
    #10 RSTN = 1'b1;
    @(posedge CK); #1;

    for (int i = 0; i < 12; i++) begin
      bus.wr_valid = tbl[i].wv; bus.wr_addr = tbl[i].wa;
      bus.wr_data = tbl[i].wd;
      bus.host_req = tbl[i].hr; bus.host_we = tbl[i].hwe;
      bus.host_addr = tbl[i].ha;
      bus.rd_valid = tbl[i].rv; bus.rd_addr = tbl[i].ra;
      #1;
      chk($sformatf("row%0d wr_ready", i), bus.wr_ready, tbl[i].ewr);
      chk($sformatf("row%0d host_gnt", i), bus.host_gnt, tbl[i].egnt);
      chk($sformatf("row%0d rd_ready", i), bus.rd_ready, tbl[i].erd);
      cycle();
    end

    for (int i = 0; i < 1500; i++) begin
      bus.wr_valid = 1'($urandom);
      bus.wr_addr = raddr();
      bus.wr_data = {$urandom, $urandom, $urandom, $urandom};
      bus.host_req = 1'($urandom);
      bus.host_we = 1'($urandom);
      bus.host_addr = raddr();
      bus.host_wdata = {$urandom, $urandom, $urandom, $urandom};
      bus.rd_valid = 1'($urandom);
      bus.rd_addr = raddr();
      cycle();
    end
    idle_in();
    cycle();
    cycle();

    // Clear sweep with every requester knocking throughout.
    bus.clr_start = 1;
    cycle();
    bus.clr_start = 0;
    m_err = 0;
    bus.wr_valid = 1; bus.wr_addr = 7;
    bus.host_req = 1; bus.host_addr = 8;
    bus.rd_valid = 1; bus.rd_addr = 9;
    bus.clr_start = 1;
    busy_n = 0; stall_n = 0; done_n = 0; exit_done = 0;
    for (int i = 0; i < 2000; i++) begin
      #1;
      if (!bus.clr_busy) begin
        exit_done = bus.clr_done;
        idle_in();
        break;
      end
      busy_n++;
      if (bus.wr_ready || bus.host_gnt || bus.rd_ready) stall_n++;
      if (bus.clr_done) done_n++;
      @(posedge CK); #1;
    end
    chk("clr busy cycles", busy_n, D);
    chk("clr stall", stall_n, 0);
    chk("clr_done on exit", exit_done, 1);
    chk("clr_done while busy", done_n, 0);
    chk("addr_err after clr", bus.addr_err, 0);
    for (int i = 0; i < 3; i++) begin
      @(posedge CK); #2;
      if (bus.clr_done) done_n++;
    end
    chk("clr_done single pulse", done_n, 0);
    for (int i = 0; i < D; i++) begin
      ref_mem[i] = '0; known[i] = 1;
    end
    bus.rd_valid = 1; bus.rd_addr = 0;
    cycle();
    idle_in();
    bus.host_req = 1; bus.host_addr = 911;
    cycle();
    idle_in();
    chk("rd_data addr0 cleared", bus.rd_data, 0);
    cycle();
    chk("host_rdata addr911 cleared", bus.host_rdata, 0);
    bus.host_req = 1; bus.host_addr = 912;
    cycle();
    idle_in();
    cycle();
    cycle();

    // Reset in the middle of a sweep.
    bus.clr_start = 1;
    cycle();
    bus.clr_start = 0;
    for (int i = 0; i < 400; i++) @(posedge CK);
    #2;
    chk("mid-clr busy", bus.clr_busy, 1);
    RSTN = 1'b0;
    #1;
    chk("abort clr_busy", bus.clr_busy, 0);
    chk("abort clr_done", bus.clr_done, 0);
    chk("abort addr_err", bus.addr_err, 0);
    chk("abort host_rvalid", bus.host_rvalid, 0);
    chk("abort rd_dvalid", bus.rd_dvalid, 0);
    chk("abort WEAN", WEAN, 1);
    #20 RSTN = 1'b1;
    model_reset();
    @(posedge CK); #1;
    for (int i = 0; i < 4; i++) begin
      bus.wr_valid = 1; bus.wr_addr = 10'(20 + i);
      bus.host_req = 1; bus.host_we = 1;
      bus.host_addr = 10'(40 + i);
      #1;
      chk($sformatf("post-rst alt%0d", i), bus.wr_ready,
          (i % 2 == 0) ? 1 : 0);
      cycle();
    end
    idle_in();
    for (int i = 0; i < 5; i++) cycle();

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/layer1_sram_ctrl.md
LAYER1_SRAM_CTRL -- requirements
Module: layer1_sram_ctrl

Interface
REQ-001 Parameters SHALL be: DEPTH, default 912, number of words; AW, default 10, address width; DW, default 128, data width.
REQ-002 Port CK, input, 1: the single clock; all state SHALL be clocked on its rising edge.
REQ-003 Port RSTN, input, 1: asynchronous active-low reset.
REQ-004 Writer ports SHALL be: wr_valid in 1; wr_ready out 1; wr_addr in AW; wr_data in DW.
REQ-005 Host ports SHALL be: host_req in 1; host_we in 1; host_addr in AW; host_wdata in DW; host_gnt out 1; host_rdata out DW; host_rvalid out 1.
REQ-006 Reader ports SHALL be: rd_valid in 1; rd_ready out 1; rd_addr in AW; rd_data out DW; rd_dvalid out 1.
REQ-007 Clear ports SHALL be: clr_start in 1 (pulse); clr_busy out 1; clr_done out 1 (pulse).
REQ-008 Error port SHALL be addr_err out 1, a sticky out-of-range flag.
REQ-009 SRAM-side ports SHALL be: OEA, OEB, WEAN, WEBN out 1; A, B out AW; DIA, DIB out DW; DOA, DOB in DW. WEAN and WEBN are active low.

Function
REQ-010 Port A SHALL serve the writer and the host; port B SHALL serve only the reader; WEBN SHALL be tied to 1.
REQ-011 Port-A arbitration SHALL be round-robin between writer and host, with the last-granted requester at lower priority; after reset the writer has priority.
REQ-012 Grant semantics: wr_ready/host_gnt are combinational; a transfer occurs when valid and ready (or req and gnt) are both high in the same cycle.
REQ-013 On an accepted write: A=addr, DIA=data, WEAN=0, OEA=0 in the same cycle.
REQ-014 On an accepted host read: A=host_addr, WEAN=1, OEA=1; host_rdata=DOA and host_rvalid=1 exactly one cycle later.
REQ-015 On an accepted reader request: B=rd_addr, OEB=1; rd_data=DOB and rd_dvalid=1 exactly one cycle later.
REQ-016 Idle port outputs: WEAN=1, OEA=0, OEB=0, A=B=0, DIA=DIB=0.
REQ-017 Same-address conflict: if port A and port B would address the same word in one cycle, rd_ready SHALL be 0 that cycle. Port A proceeds, and the read is served no earlier than the next cycle. Addresses SHALL never be altered to avoid conflicts.
REQ-018 Out-of-range requests (addr >= DEPTH) SHALL be accepted (ready/gnt=1) and then dropped: no SRAM enable, no rvalid/dvalid, addr_err set.
REQ-019 FSM states SHALL be IDLE and CLEAR.
REQ-020 IDLE to CLEAR on clr_start=1. In CLEAR, clr_busy=1; wr_ready, host_gnt and rd_ready are 0. Port A writes zero to addresses 0..DEPTH-1, one per cycle, from an AW-bit counter.
REQ-021 CLEAR to IDLE in the cycle after address DEPTH-1 is written; clr_done pulses for 1 cycle on that transition. clr_start during CLEAR SHALL be ignored.
REQ-022 In-flight read data (rvalid/dvalid) from a request accepted in the cycle before CLEAR entry SHALL still be returned.
REQ-023 addr_err SHALL clear only on reset or on clr_start.

Reset
REQ-024 On RSTN=0, asynchronously: state=IDLE, counter=0, round-robin pointer=writer, and clr_busy, clr_done, addr_err, host_rvalid, rd_dvalid all 0. host_rdata and rd_data are pass-through and need no reset.
REQ-025 Reset asserted mid-CLEAR SHALL abort the clear with no clr_done; the memory contents are then undefined.

Structure
REQ-026 A shared package SHALL hold the FSM state enum, DEPTH/AW/DW constants, and the round-robin pointer type.
REQ-027 One sub-module, rr_arb2 (two-requester round-robin arbiter), is natural; the SRAM wrapper SHALL be instantiated outside this block.

Verification
REQ-028 Scenario 1: writer writes 0x...AA at addr 5, then reader reads addr 5 -> rd_dvalid 1 cycle after acceptance, rd_data=0x...AA.
REQ-029 Scenario 2: writer and host request continuously with different addresses -> grants alternate W,H,W,H starting with W after reset.
REQ-030 Scenario 3: writer at addr 100 and reader at addr 100 in the same cycle -> rd_ready=0, write completes; read accepted next cycle and returns the new data.
REQ-031 Scenario 4: clr_start -> clr_busy high for 912 cycles, clr_done a single pulse, all requesters stalled; reads of addr 0 and 911 afterwards return 0.
REQ-032 Scenario 5: host read at addr 912 -> host_gnt=1, host_rvalid stays 0, addr_err=1 until the next clr_start.
REQ-033 Scenario 6: RSTN low at clear count 400 -> all outputs at reset values, state IDLE, no clr_done.
